// File: rtl/execute_pkg.sv
// Shared types and constants for the LC3 execute stage: control field layout,
// ALU/address selector encodings and the opcodes the stage decodes.
package execute_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC1_OFF11 = 2'b00,
        PC1_OFF9  = 2'b01,
        PC1_OFF6  = 2'b10,
        PC1_ZERO  = 2'b11
    } pcsel1_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    // Field order matches the packed E_Control bus, MSB first.
    typedef struct packed {
        alu_op_e alu_control;
        pcsel1_e pcselect1;
        logic    pcselect2;
        logic    op2select;
    } e_ctrl_t;

    function automatic logic is_store(input logic [3:0] opcode);
        return (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational datapath of the execute stage: operand bypass muxes, ALU and
// effective-address adder.
module execute_alu
    import execute_pkg::*;
(
    input  logic [10:0]       ir_low,
    input  logic [DATA_W-1:0] npc,
    input  e_ctrl_t           e_ctrl,
    input  logic [DATA_W-1:0] vsr1,
    input  logic [DATA_W-1:0] vsr2,
    input  logic [DATA_W-1:0] aluout_q,
    input  logic [DATA_W-1:0] mem_bypass_val,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] pc_result,
    output logic [DATA_W-1:0] op_b
);

    logic signed [DATA_W-1:0] op1;
    logic signed [DATA_W-1:0] op2;
    logic signed [DATA_W-1:0] offset;
    logic signed [DATA_W-1:0] base;

    // ALU bypass wins over memory bypass: it carries the younger result.
    always_comb begin
        if (bypass_alu_1)      op1 = aluout_q;
        else if (bypass_mem_1) op1 = mem_bypass_val;
        else                   op1 = vsr1;

        if (bypass_alu_2)      op_b = aluout_q;
        else if (bypass_mem_2) op_b = mem_bypass_val;
        else                   op_b = vsr2;
    end

    assign op2 = e_ctrl.op2select ? op_b : {{11{ir_low[4]}}, ir_low[4:0]};

    always_comb begin
        case (e_ctrl.alu_control)
            ALU_ADD: alu_result = op1 + op2;
            ALU_AND: alu_result = op1 & op2;
            ALU_NOT: alu_result = ~op1;
            default: alu_result = op1;
        endcase
    end

    always_comb begin
        case (e_ctrl.pcselect1)
            PC1_OFF11: offset = {{5{ir_low[10]}}, ir_low[10:0]};
            PC1_OFF9:  offset = {{7{ir_low[8]}},  ir_low[8:0]};
            PC1_OFF6:  offset = {{10{ir_low[5]}}, ir_low[5:0]};
            default:   offset = '0;
        endcase
    end

    assign base      = e_ctrl.pcselect2 ? npc : op1;
    assign pc_result = base + offset;

endmodule

// File: rtl/execute.sv
// LC3 execute stage: selects operands, runs the ALU and address adder, and
// registers the results onto the execute_out bus.
module execute
    import execute_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] npc,
    input  logic [5:0]        E_Control,
    input  logic [1:0]        W_Control_in,
    input  logic              Mem_Control_in,
    input  logic [DATA_W-1:0] VSR1,
    input  logic [DATA_W-1:0] VSR2,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    input  logic [DATA_W-1:0] Mem_Bypass_Val,
    output logic [1:0]        W_Control_out,
    output logic              Mem_Control_out,
    output logic [DATA_W-1:0] aluout,
    output logic [DATA_W-1:0] pcout,
    output logic [REG_W-1:0]  dr,
    output logic [REG_W-1:0]  sr1,
    output logic [REG_W-1:0]  sr2,
    output logic [DATA_W-1:0] IR_Exec,
    output logic [2:0]        NZP,
    output logic [DATA_W-1:0] M_Data,
    output logic              enable_execute_out
);

    logic [DATA_W-1:0] alu_result_p0;
    logic [DATA_W-1:0] pc_result_p0;
    logic [DATA_W-1:0] op_b_p0;
    logic [2:0]        nzp_p0;
    logic [3:0]        opcode;

    assign opcode = IR[15:12];
    assign sr1    = IR[8:6];
    assign sr2    = is_store(opcode) ? IR[11:9] : IR[2:0];

    execute_alu u_alu (
        .ir_low         (IR[10:0]),
        .npc            (npc),
        .e_ctrl         (e_ctrl_t'(E_Control)),
        .vsr1           (VSR1),
        .vsr2           (VSR2),
        .aluout_q       (aluout),
        .mem_bypass_val (Mem_Bypass_Val),
        .bypass_alu_1   (bypass_alu_1),
        .bypass_alu_2   (bypass_alu_2),
        .bypass_mem_1   (bypass_mem_1),
        .bypass_mem_2   (bypass_mem_2),
        .alu_result     (alu_result_p0),
        .pc_result      (pc_result_p0),
        .op_b           (op_b_p0)
    );

    always_comb begin
        nzp_p0 = '0;
        case (opcode)
            OP_BR:   nzp_p0 = IR[11:9];
            OP_JMP:  nzp_p0 = 3'b111;
            default: nzp_p0 = '0;
        endcase
    end

    // Stage boundary p0 -> execute_out. NZP drops to zero on stalled cycles so
    // downstream never evaluates the same branch twice.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            W_Control_out      <= '0;
            Mem_Control_out    <= 1'b0;
            aluout             <= '0;
            pcout              <= '0;
            dr                 <= '0;
            IR_Exec            <= '0;
            NZP                <= '0;
            M_Data             <= '0;
            enable_execute_out <= 1'b0;
        end else begin
            enable_execute_out <= enable_execute;
            if (enable_execute) begin
                W_Control_out   <= W_Control_in;
                Mem_Control_out <= Mem_Control_in;
                aluout          <= alu_result_p0;
                pcout           <= pc_result_p0;
                dr              <= IR[11:9];
                IR_Exec         <= IR;
                NZP             <= nzp_p0;
                M_Data          <= op_b_p0;
            end else begin
                NZP <= '0;
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the LC3 execute stage using directed vectors.
module tb_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [15:0] IR, npc, VSR1, VSR2, Mem_Bypass_Val;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [15:0] aluout, pcout, IR_Exec, M_Data;
    logic [2:0]  dr, sr1, sr2, NZP;
    logic        enable_execute_out;

    typedef struct {
        logic [15:0] alu, pc, ir, md;
        logic [2:0]  dr, nzp;
        logic [1:0]  w;
        logic        mem, en;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    execute dut (
        .clock              (clock),
        .reset              (reset),
        .enable_execute     (enable_execute),
        .IR                 (IR),
        .npc                (npc),
        .E_Control          (E_Control),
        .W_Control_in       (W_Control_in),
        .Mem_Control_in     (Mem_Control_in),
        .VSR1               (VSR1),
        .VSR2               (VSR2),
        .bypass_alu_1       (bypass_alu_1),
        .bypass_alu_2       (bypass_alu_2),
        .bypass_mem_1       (bypass_mem_1),
        .bypass_mem_2       (bypass_mem_2),
        .Mem_Bypass_Val     (Mem_Bypass_Val),
        .W_Control_out      (W_Control_out),
        .Mem_Control_out    (Mem_Control_out),
        .aluout             (aluout),
        .pcout              (pcout),
        .dr                 (dr),
        .sr1                (sr1),
        .sr2                (sr2),
        .IR_Exec            (IR_Exec),
        .NZP                (NZP),
        .M_Data             (M_Data),
        .enable_execute_out (enable_execute_out)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_aluout"}, aluout, 16'h0);
        chk({tag, "_pcout"}, pcout, 16'h0);
        chk({tag, "_dr"}, 16'(dr), 16'h0);
        chk({tag, "_ir_exec"}, IR_Exec, 16'h0);
        chk({tag, "_nzp"}, 16'(NZP), 16'h0);
        chk({tag, "_mdata"}, M_Data, 16'h0);
        chk({tag, "_wctl"}, 16'(W_Control_out), 16'h0);
        chk({tag, "_memctl"}, 16'(Mem_Control_out), 16'h0);
        chk({tag, "_en_out"}, 16'(enable_execute_out), 16'h0);
    endtask

    // byp = {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2}
    task automatic issue(input logic [15:0] ir, input logic [15:0] pc_next, input logic [5:0] ec,
                         input logic [1:0] w, input logic m, input logic [15:0] v1, input logic [15:0] v2,
                         input logic [15:0] mbv, input logic [3:0] byp,
                         input logic [15:0] e_alu, input logic [15:0] e_pc, input logic [15:0] e_md,
                         input logic [2:0] e_nzp, input logic [2:0] e_sr1, input logic [2:0] e_sr2);
        exp_t e;
        @(negedge clock);
        IR = ir; npc = pc_next; E_Control = ec; W_Control_in = w; Mem_Control_in = m;
        VSR1 = v1; VSR2 = v2; Mem_Bypass_Val = mbv;
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
        enable_execute = 1'b1;
        e.alu = e_alu; e.pc = e_pc; e.md = e_md; e.ir = ir; e.dr = ir[11:9];
        e.nzp = e_nzp; e.w = w; e.mem = m; e.en = 1'b1;
        q.push_back(e);
        last = e;
        #1;
        chk("sr1", 16'(sr1), 16'(e_sr1));
        chk("sr2", 16'(sr2), 16'(e_sr2));
    endtask

    task automatic hold_cycle();
        exp_t e;
        @(negedge clock);
        enable_execute = 1'b0;
        IR = 16'hFFFF; VSR1 = 16'hDEAD; VSR2 = 16'hDEAD; npc = 16'hDEAD;
        W_Control_in = 2'b11; Mem_Control_in = 1'b1;
        e = last;
        e.nzp = 3'b000;
        e.en  = 1'b0;
        q.push_back(e);
        last = e;
    endtask

    // Monitor: one registered output set per clock while expectations are queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("aluout", aluout, e.alu);
                chk("pcout", pcout, e.pc);
                chk("dr", 16'(dr), 16'(e.dr));
                chk("ir_exec", IR_Exec, e.ir);
                chk("nzp", 16'(NZP), 16'(e.nzp));
                chk("m_data", M_Data, e.md);
                chk("w_ctl", 16'(W_Control_out), 16'(e.w));
                chk("mem_ctl", 16'(Mem_Control_out), 16'(e.mem));
                chk("en_out", 16'(enable_execute_out), 16'(e.en));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable_execute = 1'b0;
        IR = '0; npc = '0; E_Control = '0; W_Control_in = '0; Mem_Control_in = 1'b0;
        VSR1 = '0; VSR2 = '0; Mem_Bypass_Val = '0;
        bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
        repeat (2) @(posedge clock);
        #1 check_zero("rst_init");
        @(negedge clock) reset = 1'b0;

        //     IR       npc      E      W     M     VSR1     VSR2     MBV      byp      alu      pc       mdata    nzp     sr1   sr2
        issue(16'h1283, 16'h3000, 6'h01, 2'b01, 1'b0, 16'h0005, 16'h0007, 16'h0000, 4'b0000, 16'h000C, 16'h0288, 16'h0007, 3'b000, 3'd2, 3'd3);
        issue(16'h127F, 16'h3001, 6'h00, 2'b01, 1'b0, 16'h0000, 16'h1234, 16'h0000, 4'b0000, 16'hFFFF, 16'h027F, 16'h1234, 3'b000, 3'd1, 3'd7);
        issue(16'h927F, 16'h3002, 6'h20, 2'b01, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 4'b0000, 16'hFF00, 16'h037E, 16'h0000, 3'b000, 3'd1, 3'd7);
        issue(16'h1260, 16'h3003, 6'h00, 2'b01, 1'b0, 16'h1111, 16'h0000, 16'h0000, 4'b0000, 16'h1111, 16'h1371, 16'h0000, 3'b000, 3'd1, 3'd0);
        issue(16'h1260, 16'h3004, 6'h00, 2'b01, 1'b0, 16'h5555, 16'h0ABC, 16'h2222, 4'b1100, 16'h1111, 16'h1371, 16'h0ABC, 3'b000, 3'd1, 3'd0);
        issue(16'h1260, 16'h3005, 6'h00, 2'b01, 1'b0, 16'h5555, 16'h0000, 16'h2222, 4'b0100, 16'h2222, 16'h2482, 16'h0000, 3'b000, 3'd1, 3'd0);
        issue(16'h1042, 16'h3006, 6'h01, 2'b01, 1'b0, 16'h0001, 16'h7777, 16'h0000, 4'b0010, 16'h2223, 16'h0043, 16'h2222, 3'b000, 3'd1, 3'd2);
        issue(16'h1042, 16'h3007, 6'h01, 2'b01, 1'b0, 16'h0001, 16'h7777, 16'h0100, 4'b0001, 16'h0101, 16'h0043, 16'h0100, 3'b000, 3'd1, 3'd2);
        issue(16'h5042, 16'h3008, 6'h11, 2'b01, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0000, 4'b0000, 16'h3030, 16'hF132, 16'h3C3C, 3'b000, 3'd1, 3'd2);
        issue(16'h0A05, 16'h3001, 6'h06, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0005, 16'h3006, 16'h0000, 3'b101, 3'd0, 3'd5);
        hold_cycle();
        issue(16'h3A02, 16'h4000, 6'h06, 2'b10, 1'b1, 16'h0000, 16'hBEEF, 16'h0000, 4'b0000, 16'h0002, 16'h4002, 16'hBEEF, 3'b000, 3'd0, 3'd5);
        issue(16'hC1C0, 16'h4001, 6'h3C, 2'b00, 1'b0, 16'h4567, 16'h0000, 16'h0000, 4'b0000, 16'h4567, 16'h4567, 16'h0000, 3'b111, 3'd7, 3'd0);
        issue(16'h62BE, 16'h4002, 6'h38, 2'b01, 1'b0, 16'h1000, 16'h0000, 16'h0000, 4'b0000, 16'h1000, 16'h0FFE, 16'h0000, 3'b000, 3'd2, 3'd6);

        // Mid-cycle asynchronous reset with non-zero outputs present.
        @(posedge clock);
        #3 reset = 1'b1;
        enable_execute = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clock);
        #1 check_zero("rst_hold");
        @(negedge clock) begin
            reset = 1'b0;
            enable_execute = 1'b0;
        end
        last = '{alu: 16'h0, pc: 16'h0, ir: 16'h0, md: 16'h0, dr: 3'h0, nzp: 3'h0, w: 2'h0, mem: 1'b0, en: 1'b0};

        issue(16'h1283, 16'h3000, 6'h01, 2'b01, 1'b0, 16'h0005, 16'h0007, 16'h0000, 4'b0000, 16'h000C, 16'h0288, 16'h0007, 3'b000, 3'd2, 3'd3);
        hold_cycle();

        @(negedge clock) enable_execute = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
